// File: rtl/bcd_convert_ctrl_if.sv
// Request/result bundle for the iterative binary-to-BCD converter.
// The master side issues start/y and the slave side returns the status and the digits.
interface bcd_convert_ctrl_if;
    logic        start;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [3:0]  ones;
    logic [3:0]  tens;
    logic [3:0]  hundreds;
    logic [3:0]  thousands;
    logic        ovf;

    modport master (
        output start, y,
        input  busy, done, ones, tens, hundreds, thousands, ovf
    );

    modport slave (
        input  start, y,
        output busy, done, ones, tens, hundreds, thousands, ovf
    );
endinterface

// File: rtl/bcd_convert_ctrl.sv
// Sequential double-dabble converter: 16 shift-add-3 cycles turn a 16-bit value into
// four BCD digits plus an overflow flag. All outputs are registered.
module bcd_convert_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    bcd_convert_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [19:0] acc;
    logic [15:0] sreg;
    logic [19:0] acc_adj;
    logic [19:0] acc_next;

    // Add 3 to every digit >= 5 before the shift so no digit can exceed 9 afterwards.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        acc_next = {acc_adj[18:0], sreg[15]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            cnt           <= 4'd0;
            acc           <= 20'd0;
            sreg          <= 16'd0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.ones      <= 4'd0;
            bus.tens      <= 4'd0;
            bus.hundreds  <= 4'd0;
            bus.thousands <= 4'd0;
            bus.ovf       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sreg     <= bus.y;
                        acc      <= 20'd0;
                        cnt      <= 4'd0;
                        bus.busy <= 1'b1;
                        state    <= StConv;
                    end
                end
                StConv: begin
                    acc  <= acc_next;
                    sreg <= {sreg[14:0], 1'b0};
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        // Publish the final (post-shift) accumulator on the leaving edge.
                        bus.ones      <= acc_next[3:0];
                        bus.tens      <= acc_next[7:4];
                        bus.hundreds  <= acc_next[11:8];
                        bus.thousands <= acc_next[15:12];
                        bus.ovf       <= (acc_next[19:16] != 4'd0);
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= StDone;
                    end
                end
                StDone: begin
                    bus.done <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Scoreboard bench for bcd_convert_ctrl: the driver queues expected results, a monitor
// pops and compares on every done pulse; timing and reset behaviour are checked inline.
module tb_bcd_convert_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   done_seen;
    int   range_bad;
    bit   mon_en;
    logic [16:0] exp_q[$];
    logic [16:0] last_exp;

    bcd_convert_ctrl_if bus ();

    bcd_convert_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] mk(input int th, input int h, input int t, input int o,
                                       input bit ov);
        return {th[3:0], h[3:0], t[3:0], o[3:0], ov};
    endfunction

    function automatic logic [16:0] outs();
        return {bus.thousands, bus.hundreds, bus.tens, bus.ones, bus.ovf};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (bus.ones > 4'd9 || bus.tens > 4'd9 || bus.hundreds > 4'd9 ||
                bus.thousands > 4'd9) begin
                range_bad++;
            end
            if (bus.done === 1'b1) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(outs()), 32'h1ffff);
                end else begin
                    chk("result", 32'(outs()), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Issue one conversion and check busy length, done latency and held outputs.
    task automatic convert(input logic [15:0] val, input logic [16:0] exp);
        int bc;
        int dk;
        bit stable;
        bc = 0;
        dk = 0;
        stable = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.y     = val;
        @(negedge clk);
        bus.start = 1'b0;
        bus.y     = ~val;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.busy === 1'b1) bc++;
            if (bus.done === 1'b1 && dk == 0) dk = k;
            if (k <= 16 && outs() !== last_exp) stable = 1'b0;
        end
        chk("busy_cycles", bc, 16);
        chk("done_latency", dk, 17);
        chk("held_during_conv", stable, 1);
        last_exp = exp;
    endtask

    initial begin
        int d0;
        int tdone[4];
        bit steady;
        int got;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        done_seen = 0;
        range_bad = 0;
        mon_en    = 1'b0;
        last_exp  = '0;
        bus.start = 1'b0;
        bus.y     = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("reset_outputs", {bus.busy, bus.done, outs()}, 0);
        reset = 1'b0;

        convert(16'h0037, mk(0, 0, 5, 5, 0));
        convert(16'd9999, mk(9, 9, 9, 9, 0));
        convert(16'd0, mk(0, 0, 0, 0, 0));
        convert(16'd10000, mk(0, 0, 0, 0, 1));
        convert(16'd65535, mk(5, 5, 3, 5, 1));

        // Second start during CONV must be ignored.
        d0 = done_seen;
        exp_q.push_back(mk(1, 2, 3, 4, 0));
        @(negedge clk);
        bus.start = 1'b1;
        bus.y     = 16'd1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.y     = 16'd4321;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        chk("single_done_ignored_start", done_seen - d0, 1);
        last_exp = mk(1, 2, 3, 4, 0);

        // Reset mid-conversion aborts without done or output update.
        convert(16'd55, mk(0, 0, 5, 5, 0));
        d0 = done_seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.y     = 16'd777;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_state", {bus.busy, bus.done, outs()}, 0);
        repeat (25) @(negedge clk);
        chk("abort_no_done", done_seen - d0, 0);
        last_exp = '0;
        convert(16'd777, mk(0, 7, 7, 7, 0));

        // Continuous start: one result every 18 cycles.
        d0 = done_seen;
        steady = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 0, 4, 2, 0));
        @(negedge clk);
        bus.start = 1'b1;
        bus.y     = 16'd42;
        for (int i = 0; i < 4; i++) begin
            got = 0;
            for (int k = 0; k < 40 && got == 0; k++) begin
                @(negedge clk);
                if (i > 0 && outs() !== mk(0, 0, 4, 2, 0)) steady = 1'b0;
                if (bus.done === 1'b1) begin
                    got = 1;
                    tdone[i] = cyc;
                end
            end
            chk("continuous_done_seen", got, 1);
        end
        bus.start = 1'b0;
        for (int i = 1; i < 4; i++) chk("done_period", tdone[i] - tdone[i-1], 18);
        repeat (25) begin
            @(negedge clk);
            if (outs() !== mk(0, 0, 4, 2, 0)) steady = 1'b0;
        end
        chk("continuous_steady", steady, 1);
        chk("continuous_done_count", done_seen - d0, 4);

        chk("queue_drained", exp_q.size(), 0);
        chk("digit_range", range_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
